fcmp_pipe: RTL and testbench

Pipelined single-precision compare unit for the FPU issue path. It accepts two IEEE-754 binary32 operands plus an op select (feq / flt / fle) over a valid/ready handshake and returns a 1-bit result with the request tag two cycles later. Unlike the plain bitwise equality comparator, it implements the team's compare semantics for signed zero, denormals and NaN. It sits between the FPU dispatch stage and the integer writeback arbiter, and supports full throughput with backpressure.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fcmp_classify.sv | 22 ++
 rtl/fcmp_pipe.sv | 138 +++++++++++++
 tb/tb_fcmp_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: binary32 field layout and compare op encoding.
package fpu_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MANT_W  = 23;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        FEQ       = 2'b00,
        FLT       = 2'b01,
        FLE       = 2'b10,
        FCMP_RSVD = 2'b11
    } fcmp_op_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/fcmp_classify.sv
// Per-operand classification: zero class (zeros and flushed denormals), NaN,
// and the unsigned magnitude key used for ordering.
module fcmp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] op,
    output logic        is_zero,
    output logic        is_nan,
    output logic [30:0] key
);

    fp32_t f;

    always_comb begin
        f       = fp32_t'(op);
        is_zero = (f.exp == '0);
        is_nan  = (f.exp == EXP_MAX) && (f.mant != '0);
        // Zero-class operands share key 0 so +0, -0 and denormals order together.
        key     = is_zero ? '0 : {f.exp, f.mant};
    end

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage binary32 compare (feq/flt/fle) with valid/ready handshake on both
// sides; S1 holds classified operands, S2 holds the final result and tag.
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic        x_zero, x_nan, y_zero, y_nan;
    logic [30:0] x_key, y_key;

    fcmp_classify u_cls_x (.op(in_x), .is_zero(x_zero), .is_nan(x_nan), .key(x_key));
    fcmp_classify u_cls_y (.op(in_y), .is_zero(y_zero), .is_nan(y_nan), .key(y_key));

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    fcmp_op_t         s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_nan_q, s1_nan_d;
    logic             s1_both_zero_q, s1_both_zero_d;
    logic             s1_sign_x_q, s1_sign_x_d;
    logic             s1_sign_y_q, s1_sign_y_d;
    logic             s1_key_lt_q, s1_key_lt_d;
    logic             s1_key_eq_q, s1_key_eq_d;

    // Stage 2 state
    logic             out_valid_q, out_valid_d;
    logic             out_z_q, out_z_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic adv1, adv2;
    logic res_eq, res_lt, res_z;

    always_comb begin
        adv2 = ~out_valid_q | out_ready;
        adv1 = ~s1_valid_q | adv2;
    end

    always_comb begin
        s1_valid_d     = adv1 ? in_valid : s1_valid_q;
        s1_op_d        = s1_op_q;
        s1_tag_d       = s1_tag_q;
        s1_nan_d       = s1_nan_q;
        s1_both_zero_d = s1_both_zero_q;
        s1_sign_x_d    = s1_sign_x_q;
        s1_sign_y_d    = s1_sign_y_q;
        s1_key_lt_d    = s1_key_lt_q;
        s1_key_eq_d    = s1_key_eq_q;
        if (adv1 && in_valid) begin
            s1_op_d        = fcmp_op_t'(in_op);
            s1_tag_d       = in_tag;
            s1_nan_d       = x_nan | y_nan;
            s1_both_zero_d = x_zero & y_zero;
            s1_sign_x_d    = in_x[31];
            s1_sign_y_d    = in_y[31];
            s1_key_lt_d    = (x_key < y_key);
            s1_key_eq_d    = (x_key == y_key);
        end
    end

    // Raw signs are safe here: a zero-class operand has key 0, so it always
    // lands on the correct side of any nonzero value of either sign.
    always_comb begin
        res_eq = s1_both_zero_q | ((s1_sign_x_q == s1_sign_y_q) & s1_key_eq_q);
        if (s1_sign_x_q != s1_sign_y_q)
            res_lt = s1_sign_x_q & ~s1_both_zero_q;
        else if (s1_sign_x_q)
            res_lt = ~s1_key_lt_q & ~s1_key_eq_q;
        else
            res_lt = s1_key_lt_q;

        case (s1_op_q)
            FEQ:     res_z = res_eq;
            FLT:     res_z = res_lt;
            FLE:     res_z = res_lt | res_eq;
            default: res_z = 1'b0;
        endcase
        if (s1_nan_q)
            res_z = 1'b0;
    end

    always_comb begin
        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        out_z_d     = out_z_q;
        out_tag_d   = out_tag_q;
        if (adv2 && s1_valid_q) begin
            out_z_d   = res_z;
            out_tag_d = s1_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_z_q     <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // NOTE: S1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_op_q        <= s1_op_d;
        s1_tag_q       <= s1_tag_d;
        s1_nan_q       <= s1_nan_d;
        s1_both_zero_q <= s1_both_zero_d;
        s1_sign_x_q    <= s1_sign_x_d;
        s1_sign_y_q    <= s1_sign_y_d;
        s1_key_lt_q    <= s1_key_lt_d;
        s1_key_eq_q    <= s1_key_eq_d;
    end

    assign in_ready  = adv1;
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_tag   = out_tag_q;
    assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed bench for fcmp_pipe: the driver pushes hand-computed results into a
// scoreboard queue; a monitor pops and compares on every output transfer.
module tb_fcmp_pipe;

    localparam int TAG_W = 5;
    localparam logic [1:0] OP_FEQ = 2'b00, OP_FLT = 2'b01, OP_FLE = 2'b10, OP_RSV = 2'b11;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_x, in_y;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_z;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    fcmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Holds the request until in_ready is seen away from the edge, then lets
    // the next rising edge transfer it. Returns 1ns after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [TAG_W-1:0] tag, input logic z);
        exp_t e;
        int   waited = 0;
        in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        e.tag = tag; e.z = z;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called right after send(): the entry is in S1, and appears on the output
    // after the next edge, so the consumer takes it at edge N+2.
    task automatic latency_check(input logic [TAG_W-1:0] tag);
        check("lat_s1_not_out", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_out_tag", {27'd0, out_tag}, {27'd0, tag});
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got tag %0d, required no output", out_tag);
            end else begin
                mon_e = sb.pop_front();
                check("sb_tag", {27'd0, out_tag}, {27'd0, mon_e.tag});
                check("sb_z", {31'd0, out_z}, {31'd0, mon_e.z});
            end
        end
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0; in_tag = '0;
        out_ready = 1'b1;

        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_z", {31'd0, out_z}, 32'd0);
        check("rst_out_tag", {27'd0, out_tag}, 32'd0);

        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        send(OP_FEQ, 32'h00000000, 32'h80000000, 5'd11, 1'b1);
        latency_check(5'd11);

        // Back-to-back directed vectors
        send(OP_FEQ, 32'h00000001, 32'h80000000, 5'd12, 1'b1);
        send(OP_FLT, 32'h00000001, 32'h80000000, 5'd13, 1'b0);
        send(OP_FLT, 32'hBF800000, 32'h3F800000, 5'd14, 1'b1);
        send(OP_FLT, 32'hC0000000, 32'hBF800000, 5'd15, 1'b1);
        send(OP_FLT, 32'h3F800000, 32'h3F800000, 5'd16, 1'b0);
        send(OP_FLE, 32'h3F800000, 32'h3F800000, 5'd17, 1'b1);
        send(OP_FLE, 32'h7FC00000, 32'h3F800000, 5'd18, 1'b0);
        send(OP_FEQ, 32'h7FC00000, 32'h3F800000, 5'd19, 1'b0);
        send(OP_FLT, 32'hFF800000, 32'h7F7FFFFF, 5'd20, 1'b1);
        send(OP_RSV, 32'h3F800000, 32'h3F800000, 5'd21, 1'b0);
        send(OP_FLE, 32'h3F800000, 32'hBF800000, 5'd22, 1'b0);
        send(OP_FLT, 32'h80000000, 32'h00000000, 5'd23, 1'b0);
        send(OP_FLE, 32'h7F800000, 32'h7F800000, 5'd24, 1'b1);
        send(OP_FLT, 32'hBF800000, 32'hC0000000, 5'd25, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 32'd0);

        // Backpressure: capacity of two, output held stable while stalled
        out_ready = 1'b0;
        send(OP_FEQ, 32'h3F800000, 32'h3F800000, 5'd1, 1'b1);
        send(OP_FLT, 32'h3F800000, 32'h40000000, 5'd2, 1'b1);
        check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_out_tag", {27'd0, out_tag}, 32'd1);
        fork
            begin
                send(OP_FLT, 32'h40000000, 32'h3F800000, 5'd3, 1'b0);
                send(OP_FLE, 32'h80000000, 32'h00000001, 5'd4, 1'b1);
            end
            begin
                repeat (3) begin
                    @(posedge clk); #1;
                    check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
                    check("bp_hold_tag", {27'd0, out_tag}, 32'd1);
                    check("bp_hold_z", {31'd0, out_z}, 32'd1);
                end
                out_ready = 1'b1;
                for (int i = 1; i <= 4; i++) begin
                    @(negedge clk);
                    check("retire_valid", {31'd0, out_valid}, 32'd1);
                    check("retire_tag", {27'd0, out_tag}, i);
                end
            end
        join
        @(negedge clk);
        check("retire_done", {31'd0, out_valid}, 32'd0);

        // Reset with both stages occupied
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(OP_FEQ, 32'h3F800000, 32'h3F800000, 5'd5, 1'b1);
        send(OP_FEQ, 32'h3F800000, 32'h3F800000, 5'd6, 1'b1);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_tag", {27'd0, out_tag}, 32'd0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        send(OP_FEQ, 32'h3F800000, 32'h3F800000, 5'd7, 1'b1);
        latency_check(5'd7);
        @(negedge clk);
        @(negedge clk);
        check("final_empty", sb.size(), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
